// File: rtl/aoi221_bist.sv
// aoi221_bist: exhaustive built-in self-test sequencer for an AOI221 cell
// (ZN = !(A | B1&B2 | C1&C2)). Walks all 32 input vectors, samples ZN after a
// programmable settle interval and reports mismatch count and pass/fail.
// Optional first-fail logging is built when AOI221_BIST_FAIL_LOG_EN is defined.
module aoi221_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       start,
  input  logic       abort,
  input  logic       zn_in,
  output logic       A,
  output logic       B1,
  output logic       B2,
  output logic       C1,
  output logic       C2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [4:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam int unsigned VEC_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(31);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] vec_q,   vec_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [ERR_W-1:0] err_q,   err_d;
  logic [VEC_W-1:0] drv_q,   drv_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
`ifdef AOI221_BIST_FAIL_LOG_EN
  logic [VEC_W-1:0] ffv_q,     ffv_d;
  logic             ffvalid_q, ffvalid_d;
`endif

  logic exp_c;
  logic mismatch_c;

  // Reference response of a healthy cell for the vector currently driven.
  assign exp_c      = ~(vec_q[4] | (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
  assign mismatch_c = zn_in ^ exp_c;

  // Next-state and result bookkeeping; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    drv_d   = '0;
`ifdef AOI221_BIST_FAIL_LOG_EN
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_SETTLE;
            vec_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
`ifdef AOI221_BIST_FAIL_LOG_EN
            ffv_d     = '0;
            ffvalid_d = 1'b0;
`endif
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (mismatch_c) begin
            err_d = err_q + ERR_W'(1);
`ifdef AOI221_BIST_FAIL_LOG_EN
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
`endif
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + VEC_W'(1);
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    drv_d  = busy_d ? vec_d : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef AOI221_BIST_FAIL_LOG_EN
  // First-failing-vector capture registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;
`else
  assign first_fail_vec   = '0;
  assign first_fail_valid = 1'b0;
`endif

  assign A         = drv_q[4];
  assign B1        = drv_q[3];
  assign B2        = drv_q[2];
  assign C1        = drv_q[1];
  assign C2        = drv_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign pass      = (state_q == ST_DONE) && (err_q == '0);

endmodule

// File: tb/tb_aoi221_bist.sv
// tb_aoi221_bist: scoreboard bench for aoi221_bist with a behavioural cell
// model (golden, stuck-at, random fault masks) and a second SETTLE_CYCLES=1 instance.
module tb_aoi221_bist;

  localparam int unsigned SETTLE = 2;
  localparam int RUN_CYC  = 32 * (SETTLE + 1);
  localparam int RUN_CYC1 = 32 * 2;

  typedef struct {
    logic [5:0] err;
    logic [4:0] ffv;
    logic       ffvalid;
    logic       pass;
    int         t0;
  } exp_t;

  logic CK = 1'b0;
  logic RN, start, abort, zn_in;
  logic A, B1, B2, C1, C2, busy, done, pass, first_fail_valid;
  logic [5:0] err_count;
  logic [4:0] first_fail_vec;

  logic start1, zn1;
  logic A1, B11, B21, C11, C21, busy1, done1, pass1, ffvalid1;
  logic [5:0] err1;
  logic [4:0] ffv1;

  int          mode;
  logic [31:0] fmask;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Healthy AOI221: low when A, or both B inputs, or both C inputs are high.
  function automatic logic ref_exp(input int v);
    return !(v >= 16 || ((v / 4) % 4) == 3 || (v % 4) == 3);
  endfunction

  // Cell-under-test behaviour: 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 flipped on masked vectors.
  function automatic logic ref_zn(input int m, input logic [31:0] msk, input int v);
    case (m)
      0:       return ref_exp(v);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ref_exp(v) ^ msk[v];
    endcase
  endfunction

  always_comb zn_in = ref_zn(mode, fmask, int'({A, B1, B2, C1, C2}));
  always_comb zn1   = ref_zn(0, 32'd0, int'({A1, B11, B21, C11, C21}));

  aoi221_bist #(.SETTLE_CYCLES(SETTLE)) dut (
    .CK(CK), .RN(RN), .start(start), .abort(abort), .zn_in(zn_in),
    .A(A), .B1(B1), .B2(B2), .C1(C1), .C2(C2),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  aoi221_bist #(.SETTLE_CYCLES(1)) dut_s1 (
    .CK(CK), .RN(RN), .start(start1), .abort(1'b0), .zn_in(zn1),
    .A(A1), .B1(B11), .B2(B21), .C1(C11), .C2(C21),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mismatch count and first failing index over vectors 0..nvec-1 (first = -1 if none).
  task automatic model(input int m, input logic [31:0] msk, input int nvec,
                       output int err, output int first);
    err   = 0;
    first = -1;
    for (int v = 0; v < nvec; v++) begin
      if (ref_zn(m, msk, v) != ref_exp(v)) begin
        err++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic check_first_fail(input string tag, input int first);
`ifdef AOI221_BIST_FAIL_LOG_EN
    check({tag, "_ffvalid"}, first_fail_valid, (first >= 0) ? 1 : 0);
    check({tag, "_ffv"}, first_fail_vec, (first >= 0) ? first : 0);
`else
    check({tag, "_ffvalid"}, first_fail_valid, 0);
    check({tag, "_ffv"}, first_fail_vec, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drive"}, {A, B1, B2, C1, C2}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_ffv"}, first_fail_vec, 0);
    check({tag, "_ffvalid"}, first_fail_valid, 0);
  endtask

  // Monitor: compares each completed run against the oldest queued expectation.
  task automatic monitor();
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge CK);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("run_len", cyc - e.t0, RUN_CYC);
          check("busy_at_done", busy, 0);
          check("err_count", err_count, e.err);
          check("pass", pass, e.pass);
          check("ffvalid", first_fail_valid, e.ffvalid);
          check("ffv", first_fail_vec, e.ffv);
          check("drive_at_done", {A, B1, B2, C1, C2}, 0);
        end
      end
      done_prev = done;
    end
  endtask

  // Issue one complete run, queue its expected result, wait (bounded) for done.
  task automatic run_full(input int m, input logic [31:0] msk, input bit ign_start);
    exp_t e;
    int   err, first;
    bit   got;
    @(negedge CK);
    mode  = m;
    fmask = msk;
    start = 1'b1;
    @(posedge CK);
    #1;
    start = 1'b0;
    model(m, msk, 32, err, first);
    e.err  = 6'(err);
    e.pass = (err == 0);
`ifdef AOI221_BIST_FAIL_LOG_EN
    e.ffvalid = (first >= 0);
    e.ffv     = (first >= 0) ? 5'(first) : 5'd0;
`else
    e.ffvalid = 1'b0;
    e.ffv     = 5'd0;
`endif
    e.t0 = cyc;
    sb_q.push_back(e);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_vec", {A, B1, B2, C1, C2}, 0);
    if (ign_start) begin
      repeat (40) @(negedge CK);
      start = 1'b1;
      @(negedge CK);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < RUN_CYC + 8; i++) begin
      @(negedge CK);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=no_done expected=done (t=%0t)", $time);
    end
    repeat (3) @(negedge CK);
    check("done_held", done, 1);
  endtask

  initial begin
    int   err, first, t;
    bit   got;
    RN     = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    fmask  = 32'd0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge CK);
    check_all_zero("reset");
    RN = 1'b1;
    repeat (4) @(negedge CK);
    check_all_zero("idle_no_start");

    // Golden cell with an ignored mid-run start, then stuck-at faults.
    run_full(0, 32'd0, 1'b1);
    run_full(1, 32'd0, 1'b0);
    run_full(2, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) run_full(3, $urandom() & $urandom(), 1'b0);
    run_full(3, 32'h8000_0000, 1'b0);

    // Abort during vector 10, coinciding with a start that must lose.
    @(negedge CK);
    mode  = 1;
    start = 1'b1;
    @(posedge CK);
    #1;
    start = 1'b0;
    repeat (30) @(posedge CK);
    @(negedge CK);
    abort = 1'b1;
    start = 1'b1;
    @(posedge CK);
    #1;
    abort = 1'b0;
    start = 1'b0;
    model(1, 32'd0, 10, err, first);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_drive", {A, B1, B2, C1, C2}, 0);
    check("abort_err_kept", err_count, err);
    check_first_fail("abort", first);
    repeat (RUN_CYC) @(negedge CK);
    check("abort_stays_idle", {busy, done}, 0);

    run_full(0, 32'd0, 1'b0);

    // Asynchronous reset in the middle of vector 20.
    @(negedge CK);
    mode  = 1;
    start = 1'b1;
    @(posedge CK);
    #1;
    start = 1'b0;
    repeat (61) @(posedge CK);
    #3;
    model(1, 32'd0, 20, err, first);
    check("pre_reset_err", err_count, err);
    RN = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge CK);
    RN = 1'b1;
    repeat (5) @(negedge CK);
    check_all_zero("post_reset");

    // Shortest settle interval: 64-cycle run.
    @(negedge CK);
    start1 = 1'b1;
    @(posedge CK);
    #1;
    start1 = 1'b0;
    t   = cyc;
    got = 1'b0;
    for (int i = 0; i < RUN_CYC1 + 8; i++) begin
      @(negedge CK);
      if (done1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL s1_timeout actual=no_done expected=done (t=%0t)", $time);
    end
    check("s1_len", cyc - t, RUN_CYC1);
    check("s1_pass", pass1, 1);
    check("s1_err", err1, 0);
    check("s1_ff", {ffvalid1, ffv1}, 0);
    check("s1_busy", busy1, 0);
    check("s1_drive", {A1, B11, B21, C11, C21}, 0);

    repeat (2) @(negedge CK);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
